// File: rtl/control_sequencer.sv
// SAP control sequencer: T1..T6 ring counter clocked on the falling edge,
// with the control word decoded combinationally from T-state, opcode and flags.
module control_sequencer #(
    parameter bit SKIP_IDLE = 1'b0
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] IR_OPCODE,
    input  logic       FLAG_C,
    input  logic       FLAG_Z,
    output logic       PC_INC,
    output logic       _JMP,
    output logic       _EN_PC_OUT,
    output logic       _LOAD_MAR,
    output logic       _EN_RAM_OUT,
    output logic       _WE_RAM,
    output logic       _LOAD_IR,
    output logic       _EN_IR_OUT,
    output logic       _LOAD_A,
    output logic       _EN_A_OUT,
    output logic       _LOAD_B,
    output logic       _EN_ALU_OUT,
    output logic       SUB,
    output logic       _LOAD_FLAGS,
    output logic       _LOAD_OUT,
    output logic       HALT,
    output logic [2:0] T_STATE
);

    typedef enum logic [2:0] {
        T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
    } t_state_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STA = 4'h3,
        OP_LDI = 4'h4, OP_JMP = 4'h5, OP_JC  = 4'h6, OP_JZ  = 4'h7,
        OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    t_state_e state;
    t_state_e last_t;
    logic     halt_q;

    logic pc_inc, jmp, en_pc, ld_mar, en_ram, we_ram, ld_ir, en_ir;
    logic ld_a, en_a, ld_b, en_alu, sub, ld_flags, ld_out;

    always_comb begin
        last_t = T6;
        if (SKIP_IDLE) begin
            case (opcode_e'(IR_OPCODE))
                OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_t = T4;
                OP_LDA, OP_STA:                               last_t = T5;
                OP_ADD, OP_SUB:                               last_t = T6;
                default:                                      last_t = T3;
            endcase
        end
    end

    // HLT is caught on the T3->T4 edge so the halt flag and T4 appear together.
    always_ff @(negedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= T1;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            if (state == T3 && IR_OPCODE == OP_HLT) begin
                state  <= T4;
                halt_q <= 1'b1;
            end else if (state >= last_t) begin
                state <= T1;
            end else begin
                state <= t_state_e'(state + 3'd1);
            end
        end
    end

    always_comb begin
        pc_inc = 1'b0; jmp  = 1'b0; en_pc  = 1'b0; ld_mar   = 1'b0;
        en_ram = 1'b0; we_ram = 1'b0; ld_ir = 1'b0; en_ir   = 1'b0;
        ld_a   = 1'b0; en_a = 1'b0; ld_b   = 1'b0; en_alu   = 1'b0;
        sub    = 1'b0; ld_flags = 1'b0; ld_out = 1'b0;
        if (!RESET && !halt_q) begin
            case (state)
                T1: begin en_pc = 1'b1; ld_mar = 1'b1; end
                T2: pc_inc = 1'b1;
                T3: begin en_ram = 1'b1; ld_ir = 1'b1; end
                T4: begin
                    case (opcode_e'(IR_OPCODE))
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin en_ir = 1'b1; ld_mar = 1'b1; end
                        OP_LDI: begin en_ir = 1'b1; ld_a = 1'b1; end
                        OP_JMP: begin en_ir = 1'b1; jmp = 1'b1; end
                        OP_JC:  begin en_ir = FLAG_C; jmp = FLAG_C; end
                        OP_JZ:  begin en_ir = FLAG_Z; jmp = FLAG_Z; end
                        OP_OUT: begin en_a = 1'b1; ld_out = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode_e'(IR_OPCODE))
                        OP_LDA:         begin en_ram = 1'b1; ld_a = 1'b1; end
                        OP_ADD, OP_SUB: begin en_ram = 1'b1; ld_b = 1'b1; end
                        OP_STA:         begin en_a = 1'b1; we_ram = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    if (IR_OPCODE == OP_ADD || IR_OPCODE == OP_SUB) begin
                        en_alu   = 1'b1;
                        ld_a     = 1'b1;
                        ld_flags = 1'b1;
                        sub      = (IR_OPCODE == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign PC_INC      = pc_inc;
    assign _JMP        = ~jmp;
    assign _EN_PC_OUT  = ~en_pc;
    assign _LOAD_MAR   = ~ld_mar;
    assign _EN_RAM_OUT = ~en_ram;
    assign _WE_RAM     = ~we_ram;
    assign _LOAD_IR    = ~ld_ir;
    assign _EN_IR_OUT  = ~en_ir;
    assign _LOAD_A     = ~ld_a;
    assign _EN_A_OUT   = ~en_a;
    assign _LOAD_B     = ~ld_b;
    assign _EN_ALU_OUT = ~en_alu;
    assign SUB         = sub;
    assign _LOAD_FLAGS = ~ld_flags;
    assign _LOAD_OUT   = ~ld_out;
    assign HALT        = halt_q;
    assign T_STATE     = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: one instance per SKIP_IDLE setting,
// expectations from an instruction-level model, checked at each rising edge.
module tb_control_sequencer;

    // Control word bit positions (MSB first), packed as the DUT ports are listed.
    localparam int B_PC_INC = 15, B_JMP = 14, B_EN_PC = 13, B_LD_MAR = 12, B_EN_RAM = 11;
    localparam int B_WE_RAM = 10, B_LD_IR = 9, B_EN_IR = 8, B_LD_A = 7, B_EN_A = 6;
    localparam int B_LD_B = 5, B_EN_ALU = 4, B_SUB = 3, B_LD_FLAGS = 2, B_LD_OUT = 1, B_HALT = 0;
    localparam logic [15:0] LOWMASK = 16'b0111_1111_1111_0110;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] w;
    } exp_t;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic       rst [2];
    logic [3:0] op  [2];
    logic       fc  [2];
    logic       fz  [2];
    wire  [15:0] w0, w1;
    wire  [2:0]  ts0, ts1;

    control_sequencer #(.SKIP_IDLE(1'b0)) dut0 (
        .CLOCK(CLOCK), .RESET(rst[0]), .IR_OPCODE(op[0]), .FLAG_C(fc[0]), .FLAG_Z(fz[0]),
        .PC_INC(w0[15]), ._JMP(w0[14]), ._EN_PC_OUT(w0[13]), ._LOAD_MAR(w0[12]),
        ._EN_RAM_OUT(w0[11]), ._WE_RAM(w0[10]), ._LOAD_IR(w0[9]), ._EN_IR_OUT(w0[8]),
        ._LOAD_A(w0[7]), ._EN_A_OUT(w0[6]), ._LOAD_B(w0[5]), ._EN_ALU_OUT(w0[4]),
        .SUB(w0[3]), ._LOAD_FLAGS(w0[2]), ._LOAD_OUT(w0[1]), .HALT(w0[0]), .T_STATE(ts0)
    );

    control_sequencer #(.SKIP_IDLE(1'b1)) dut1 (
        .CLOCK(CLOCK), .RESET(rst[1]), .IR_OPCODE(op[1]), .FLAG_C(fc[1]), .FLAG_Z(fz[1]),
        .PC_INC(w1[15]), ._JMP(w1[14]), ._EN_PC_OUT(w1[13]), ._LOAD_MAR(w1[12]),
        ._EN_RAM_OUT(w1[11]), ._WE_RAM(w1[10]), ._LOAD_IR(w1[9]), ._EN_IR_OUT(w1[8]),
        ._LOAD_A(w1[7]), ._EN_A_OUT(w1[6]), ._LOAD_B(w1[5]), ._EN_ALU_OUT(w1[4]),
        .SUB(w1[3]), ._LOAD_FLAGS(w1[2]), ._LOAD_OUT(w1[1]), .HALT(w1[0]), .T_STATE(ts1)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    event mid_ev;

    int   mt [2];
    bit   mh [2];
    bit   fix_flags = 1'b0;
    logic fix_c = 1'b0, fix_z = 1'b0;
    int   rst_rate = 0;

    // Microcode table: which signals are asserted in T-state t of opcode o.
    function automatic logic [15:0] asserted(int t, logic [3:0] o, logic c, logic z);
        logic [15:0] a = '0;
        if (t == 1) begin a[B_EN_PC] = 1; a[B_LD_MAR] = 1; end
        if (t == 2) a[B_PC_INC] = 1;
        if (t == 3) begin a[B_EN_RAM] = 1; a[B_LD_IR] = 1; end
        if (t == 4) begin
            if (o <= 4'd3)       begin a[B_EN_IR] = 1; a[B_LD_MAR] = 1; end
            if (o == 4'd4)       begin a[B_EN_IR] = 1; a[B_LD_A] = 1; end
            if (o == 4'd5 || (o == 4'd6 && c) || (o == 4'd7 && z))
                                 begin a[B_EN_IR] = 1; a[B_JMP] = 1; end
            if (o == 4'd14)      begin a[B_EN_A] = 1; a[B_LD_OUT] = 1; end
        end
        if (t == 5) begin
            if (o == 4'd0)                begin a[B_EN_RAM] = 1; a[B_LD_A] = 1; end
            if (o == 4'd1 || o == 4'd2)   begin a[B_EN_RAM] = 1; a[B_LD_B] = 1; end
            if (o == 4'd3)                begin a[B_EN_A] = 1; a[B_WE_RAM] = 1; end
        end
        if (t == 6 && (o == 4'd1 || o == 4'd2)) begin
            a[B_EN_ALU] = 1; a[B_LD_A] = 1; a[B_LD_FLAGS] = 1; a[B_SUB] = (o == 4'd2);
        end
        return a;
    endfunction

    function automatic int instr_len(int k, logic [3:0] o);
        if (k == 0) return 6;
        case (o)
            4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd15: return 4;
            4'd0, 4'd3:                           return 5;
            4'd1, 4'd2:                           return 6;
            default:                              return 3;
        endcase
    endfunction

    function automatic exp_t expect_now(int k, logic [3:0] o, logic c, logic z, logic r);
        exp_t e;
        if (r)          begin e.t = 3'd1; e.w = LOWMASK; end
        else if (mh[k]) begin e.t = 3'd4; e.w = LOWMASK | 16'h0001; end
        else            begin e.t = 3'(mt[k]); e.w = asserted(mt[k], o, c, z) ^ LOWMASK; end
        return e;
    endfunction

    task automatic advance(int k, logic [3:0] o, logic r);
        if (r) begin mt[k] = 1; mh[k] = 0; end
        else if (mh[k]) ;
        else if (mt[k] == 3 && o == 4'hF) begin mt[k] = 4; mh[k] = 1; end
        else if (mt[k] >= instr_len(k, o)) mt[k] = 1;
        else mt[k] = mt[k] + 1;
    endtask

    task automatic push(int k, exp_t e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // One clock period starting just after a falling edge.
    task automatic step(int k, logic [3:0] o, logic r);
        op[k]  = o;
        rst[k] = r;
        fc[k]  = fix_flags ? fix_c : 1'($urandom_range(1));
        fz[k]  = fix_flags ? fix_z : 1'($urandom_range(1));
        push(k, expect_now(k, o, fc[k], fz[k], r));
        if (!r && !mh[k] && mt[k] == 4 && (o == 4'd6 || o == 4'd7)) begin
            @(posedge CLOCK); #1;
            fc[k] = ~fc[k];
            fz[k] = ~fz[k];
            push(k, expect_now(k, o, fc[k], fz[k], r));
            #1 -> mid_ev;
        end
        @(negedge CLOCK);
        advance(k, o, r);
        #1;
    endtask

    task automatic instr(int k, logic [3:0] o);
        int  n = 0;
        logic r;
        do begin
            r = (rst_rate > 0) && ($urandom_range(rst_rate - 1) == 0);
            step(k, (mt[k] < 3) ? 4'($urandom) : o, r);
            n++;
        end while (mt[k] != 1 && !mh[k] && n < 8);
        if (mh[k]) begin
            repeat (10) step(k, 4'($urandom), 1'b0);
            step(k, o, 1'b1);
        end
    endtask

    task automatic chk(int k);
        exp_t e;
        logic [15:0] w;
        logic [2:0]  ts;
        int lows;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) return;
        e  = (k == 0) ? q0.pop_front() : q1.pop_front();
        w  = (k == 0) ? w0 : w1;
        ts = (k == 0) ? ts0 : ts1;
        checks++;
        if (ts !== e.t) begin
            errors++;
            $display("FAIL dut%0d t_state @%0t: got %0d expected %0d", k, $time, ts, e.t);
        end
        checks++;
        if (w !== e.w) begin
            errors++;
            $display("FAIL dut%0d word @%0t (T%0d): got %b expected %b", k, $time, e.t, w, e.w);
        end
        lows = 5 - $countones({w[B_EN_PC], w[B_EN_RAM], w[B_EN_IR], w[B_EN_A], w[B_EN_ALU]});
        checks++;
        if (lows > 1) begin
            errors++;
            $display("FAIL dut%0d bus_drivers @%0t: got %0d active expected <=1", k, $time, lows);
        end
    endtask

    always begin
        @(posedge CLOCK or mid_ev);
        chk(0);
        chk(1);
    end

    initial begin
        rst[0] = 1; rst[1] = 1;
        op[0] = '0; op[1] = '0;
        fc[0] = 0; fc[1] = 0; fz[0] = 0; fz[1] = 0;
        mt[0] = 1; mt[1] = 1; mh[0] = 0; mh[1] = 0;
        @(negedge CLOCK); #1;

        for (int k = 0; k < 2; k++) begin
            step(k, 4'h0, 1'b1);
            step(k, 4'h0, 1'b1);
            if (k == 0) begin
                instr(0, 4'h1);
                fix_flags = 1; fix_c = 0; fix_z = 0;
                instr(0, 4'h6);
                fix_c = 1;
                instr(0, 4'h6);
                fix_flags = 0;
                instr(0, 4'hF);
                instr(0, 4'h4);
                step(0, 4'h2, 1'b0);
                step(0, 4'h2, 1'b0);
                step(0, 4'h2, 1'b0);
                step(0, 4'h2, 1'b0);
                step(0, 4'h2, 1'b1);
                step(0, 4'h2, 1'b1);
            end else begin
                instr(1, 4'h4);
                instr(1, 4'h0);
                instr(1, 4'h1);
                instr(1, 4'hF);
            end
            for (int o = 0; o < 16; o++) instr(k, 4'(o));
            rst_rate = 40;
            repeat (50) instr(k, 4'($urandom));
            rst_rate = 0;
            instr(k, 4'h0);
            step(k, 4'h0, 1'b1);
        end

        repeat (3) @(posedge CLOCK);
        #1;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
